// File: rtl/opb_register_ppc2simulink.sv
// OPB slave register: PPC writes a word that is held for user fabric logic.
// Ports: OPB slave bus in/out, user_data_out/strobe out, user_ack in.
// Optional write counter at offset 0x8 when OPB_P2S_WRCOUNT_EN is defined.
module opb_register_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR = 32'h0108B400,
  parameter logic [31:0] C_HIGHADDR = 32'h0108B4FF,
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32,
  parameter logic [31:0] C_DEFAULT = 32'h00000000
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [31:0]               user_data_out,
  output logic                      user_data_strobe,
  input  logic                      user_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_WAIT
  } state_t;

  state_t state;
  state_t state_n;

  logic        hit;
  logic        accept;
  logic [1:0]  off;
  logic        wr_en;
  logic [31:0] wdata;
  logic [31:0] data_n;
  logic [31:0] rd_word;
  logic [31:0] rd_q;
  logic [31:0] count_word;
  logic        pending;
  logic        unused_ok;

  assign unused_ok = OPB_seqAddr;

  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign hit = OPB_select
            && (OPB_ABus >= C_BASEADDR)
            && (OPB_ABus <= C_HIGHADDR);

  // Only a fresh request from IDLE is serviced; a held select
  // after the ack must not produce a second transfer.
  assign accept = (state == S_IDLE) && hit;
  assign off    = OPB_ABus[28:29];
  assign wdata  = OPB_DBus;

  assign wr_en = accept && !OPB_RNW
              && (off == 2'd0) && (|OPB_BE);

  // OPB byte lane b (big-endian) maps to bits [31-8b -: 8].
  always_comb begin
    data_n = user_data_out;
    for (int b = 0; b < 4; b++) begin
      if (OPB_BE[b]) begin
        data_n[31-8*b -: 8] = wdata[31-8*b -: 8];
      end
    end
  end

`ifdef OPB_P2S_WRCOUNT_EN
  logic [15:0] wr_count;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      wr_count <= 16'h0000;
    end else if (wr_en) begin
      wr_count <= wr_count + 16'h0001;
    end
  end

  assign count_word = {16'h0000, wr_count};
`else
  assign count_word = 32'h00000000;
`endif

  always_comb begin
    rd_word = 32'h00000000;
    case (off)
      2'd0:    rd_word = user_data_out;
      2'd1:    rd_word = {31'b0, pending};
      2'd2:    rd_word = count_word;
      default: rd_word = 32'h00000000;
    endcase
  end

  // FSM: state register
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM: next state
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (hit) state_n = S_ACK;
      S_ACK:  state_n = S_WAIT;
      S_WAIT: if (!OPB_select) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    Sl_xferAck = (state == S_ACK);
  end

  // Read data is captured on the accepting edge and cleared
  // on the next, so the bus is non-zero only in the ack cycle.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      rd_q <= 32'h00000000;
    end else if (accept && OPB_RNW) begin
      rd_q <= rd_word;
    end else begin
      rd_q <= 32'h00000000;
    end
  end

  assign Sl_DBus = rd_q;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      user_data_out    <= C_DEFAULT;
      user_data_strobe <= 1'b0;
      pending          <= 1'b0;
    end else begin
      user_data_strobe <= wr_en;
      if (wr_en) begin
        user_data_out <= data_n;
      end
      // A new write outranks a simultaneous acknowledge.
      if (wr_en) begin
        pending <= 1'b1;
      end else if (user_ack) begin
        pending <= 1'b0;
      end
    end
  end

endmodule
